sumador_segmentado: RTL and testbench
=====================================

# sumador_segmentado

Parametrised, multi-cycle unsigned adder/subtractor. It is the successor of the fixed 4-bit sumador. Operands of WIDTH bits are accepted through a valid/ready handshake and processed CHUNK bits per enabled clock cycle, LSB chunk first, with the carry held in a register between chunks. The result is presented with a carry/borrow flag through a second valid/ready handshake. It sits between an operand producer (tester or datapath) and a result consumer, with `enb` acting as a global stall.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per enabled cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  global enable; when 0, all state and outputs hold.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- modo  input  1  0 = add (a+b), 1 = subtract (a−b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  c/cout hold a final result.
- out_ready  input  1  consumer takes the result.
- c  output  WIDTH  result.
- cout  output  1  add: carry out; subtract: 1 = no borrow (a ≥ b).

## Operation
- FSM states:
  - IDLE: waiting for operands.
  - SUMA: chunk index k runs 0..NCHUNK−1.
  - LISTO: result held.
- IDLE → SUMA on `enb & in_valid & in_ready`.
  - On acceptance: latch a, b and modo; k=0; c=0.
  - Carry register initialised to modo (1 for subtract).
- Effective B is `b` for add and `~b` for subtract, giving two's complement a + ~b + 1.
- SUMA, per enabled cycle:
  - c[k*CHUNK +: CHUNK] = a_k + b_eff_k + carry; carry = chunk carry-out; k++.
  - After chunk NCHUNK−1, move to LISTO with out_valid=1 and cout = final carry.
- LISTO → IDLE on `enb & out_ready`. c and cout hold their values until the next acceptance.
- No overlap: operands are not accepted in SUMA or LISTO.
- in_ready = (state==IDLE) & !reset. in_ready does not depend on enb, but a transfer only occurs when enb=1.
- Arithmetic is modulo 2^WIDTH. Without saturation, the result wraps.

## Timing
- Reset values:
  - Outputs: out_valid=0, c=0, cout=0; in_ready=0 while reset=1.
  - Internal: state=IDLE, k=0, carry=0.
- Reset is asserted mid-operation (SUMA or LISTO):
  - The operation is aborted and the result is lost.
  - The first cycle after reset deasserts has in_ready=1.
- Latency: acceptance edge to out_valid=1 is NCHUNK enabled cycles (4 with defaults).
- Throughput: one operation per NCHUNK+2 cycles at best, because IDLE and LISTO each take at least one cycle.
- enb=0 on any cycle freezes FSM, k, carry, c, cout and out_valid. Latency stretches by the number of disabled cycles.
- in_valid/out_ready asserted together with enb=0: no transfer occurs.
- out_ready=0 in LISTO: result held indefinitely and in_ready stays 0.
- reset has priority over enb.

## Configuration
- SUMADOR_SAT_EN defined: saturation is applied when the last chunk is written (entering LISTO).
  - Add with carry=1: c = all ones.
  - Subtract with borrow (final carry=0): c = 0.
  - cout still reports the raw carry/borrow.
- SUMADOR_SAT_EN undefined: c is the wrapped modulo result, and no saturation logic is present.

## Structure
- Package sumador_pkg contains:
  - The state enum {IDLE, SUMA, LISTO}.
  - The mode constants MODO_SUMA=0 and MODO_RESTA=1.
- Sub-module sumador_bloque: combinational CHUNK-bit adder with inputs (x, y, cin) and outputs (s, co), instantiated once in sumador_segmentado.
- The index counter is $clog2(NCHUNK) bits wide, minimum 1.

## Test plan
All scenarios use defaults WIDTH=16, CHUNK=4 and enb=1 unless stated.
- Reset, then add a=0x0000, b=0x0001 → out_valid 4 cycles after acceptance, c=0x0001, cout=0.
- Add a=0x00FF, b=0x0001 → c=0x0100, cout=0 (carry propagates across chunks 0→1→2).
- Add a=0xFFFF, b=0x0002 → c=0x0001, cout=1; with SUMADOR_SAT_EN, c=0xFFFF, cout=1.
- Subtract a=0x0005, b=0x0007 → c=0xFFFE, cout=0; with SUMADOR_SAT_EN, c=0x0000. Subtract a=0x0007, b=0x0005 → c=0x0002, cout=1.
- Stall and backpressure:
  - enb=0 for 2 cycles during SUMA → out_valid arrives 6 cycles after acceptance, with an unchanged result.
  - out_ready=0 for 3 cycles in LISTO → c held, in_ready=0; the next operation is accepted only after the out_ready handshake.
- reset=1 for one cycle during SUMA (k=2) → next cycle out_valid=0, c=0, cout=0; after reset deasserts, in_ready=1 and a fresh add of 0x1234+0x1111 gives c=0x2345.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared types and constants for the multi-cycle adder/subtractor.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUMA  = 2'd1,
        LISTO = 2'd2
    } estado_t;

    localparam logic MODO_SUMA  = 1'b0;
    localparam logic MODO_RESTA = 1'b1;

endpackage

// File: rtl/sumador_if.sv
// Operand and result handshakes of sumador_segmentado.
interface sumador_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             modo;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             cout;

    modport master (
        output in_valid, modo, a, b, out_ready,
        input  in_ready, out_valid, c, cout
    );

    modport slave (
        input  in_valid, modo, a, b, out_ready,
        output in_ready, out_valid, c, cout
    );
endinterface

// File: rtl/sumador_bloque.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module sumador_bloque #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    assign {co, s} = (CHUNK+1)'(x) + (CHUNK+1)'(y) + (CHUNK+1)'(cin);
endmodule

// File: rtl/sumador_segmentado.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per enabled cycle.
// Define SUMADOR_SAT_EN to saturate the result instead of wrapping.
module sumador_segmentado
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enb,
    sumador_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    estado_t          estado, estado_nx;
    logic [KW-1:0]    k, k_nx;
    logic             carry, carry_nx;
    logic             modo_q, modo_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic [WIDTH-1:0] c_q, c_nx;
    logic             cout_q, cout_nx;
    logic             ov_q, ov_nx;

    logic [CHUNK-1:0] s_c;
    logic             co_c;

    // Operands shift right so the active chunk always sits in the low bits.
    sumador_bloque #(.CHUNK(CHUNK)) u_bloque (
        .x   (a_q[CHUNK-1:0]),
        .y   (b_q[CHUNK-1:0]),
        .cin (carry),
        .s   (s_c),
        .co  (co_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= IDLE;
            k      <= '0;
            carry  <= 1'b0;
            modo_q <= MODO_SUMA;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            cout_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            estado <= estado_nx;
            k      <= k_nx;
            carry  <= carry_nx;
            modo_q <= modo_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            c_q    <= c_nx;
            cout_q <= cout_nx;
            ov_q   <= ov_nx;
        end
    end

    always_comb begin
        estado_nx = estado;
        k_nx      = k;
        carry_nx  = carry;
        modo_nx   = modo_q;
        a_nx      = a_q;
        b_nx      = b_q;
        c_nx      = c_q;
        cout_nx   = cout_q;
        ov_nx     = ov_q;

        if (enb) begin
            case (estado)
                IDLE: begin
                    if (bus.in_valid) begin
                        estado_nx = SUMA;
                        a_nx      = bus.a;
                        // Subtract as a + ~b + 1: invert b here, seed carry with 1.
                        b_nx      = (bus.modo == MODO_RESTA) ? ~bus.b : bus.b;
                        modo_nx   = bus.modo;
                        carry_nx  = bus.modo;
                        k_nx      = '0;
                        c_nx      = '0;
                    end
                end
                SUMA: begin
                    for (int unsigned i = 0; i < NCHUNK; i++) begin
                        if (k == KW'(i)) c_nx[i*CHUNK +: CHUNK] = s_c;
                    end
                    a_nx     = a_q >> CHUNK;
                    b_nx     = b_q >> CHUNK;
                    carry_nx = co_c;
                    k_nx     = k + KW'(1);
                    if (k == KW'(NCHUNK - 1)) begin
                        estado_nx = LISTO;
                        ov_nx     = 1'b1;
                        cout_nx   = co_c;
                        k_nx      = '0;
`ifdef SUMADOR_SAT_EN
                        if (modo_q == MODO_SUMA && co_c) begin
                            c_nx = '1;
                        end else if (modo_q == MODO_RESTA && !co_c) begin
                            c_nx = '0;
                        end
`endif
                    end
                end
                LISTO: begin
                    if (bus.out_ready) begin
                        estado_nx = IDLE;
                        ov_nx     = 1'b0;
                    end
                end
                default: estado_nx = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (estado == IDLE) && !reset;
    assign bus.out_valid = ov_q;
    assign bus.c         = c_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed self-checking bench for sumador_segmentado (WIDTH=16, CHUNK=4).
module tb_sumador_segmentado;

    logic clk;
    logic reset;
    logic enb;
    int   n_cmp;
    int   n_err;

    sumador_if #(.WIDTH(16)) bus ();

    sumador_segmentado #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; optional enb stall after stall_after SUMA cycles.
    task automatic run_op(input string tag, input logic m, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] ec, input logic ecout,
                          input int stall_after, input int stall_len);
        int  lat;
        bit  seen;
        bit  rdy;
        rdy = 1'b0;
        for (int i = 0; i < 10 && !rdy; i++) begin
            if (bus.in_ready) rdy = 1'b1;
            else tick();
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.modo     = m;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~x;
        bus.b        = ~y;
        bus.modo     = ~m;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (stall_len > 0 && i == stall_after) enb = 1'b0;
            if (i == stall_after + stall_len) enb = 1'b1;
            tick();
            lat++;
            if (bus.out_valid) seen = 1'b1;
        end
        enb = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'(4 + stall_len));
        check({tag, "_c"}, 32'(bus.c), 32'(ec));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        enb           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.modo      = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_c", 32'(bus.c), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("add_0_1", 1'b0, 16'h0000, 16'h0001, 16'h0001, 1'b0, 0, 0);
        run_op("add_ff_1", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 0, 0);
`ifdef SUMADOR_SAT_EN
        run_op("add_ovf", 1'b0, 16'hFFFF, 16'h0002, 16'hFFFF, 1'b1, 0, 0);
        run_op("sub_5_7", 1'b1, 16'h0005, 16'h0007, 16'h0000, 1'b0, 0, 0);
`else
        run_op("add_ovf", 1'b0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 0, 0);
        run_op("sub_5_7", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 0, 0);
`endif
        run_op("sub_7_5", 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 0, 0);
        run_op("sub_eq", 1'b1, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 0, 0);
        run_op("stall", 1'b0, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1, 2);

        // in_valid with enb=0 must not start an operation
        enb          = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 16'h0101;
        bus.b        = 16'h0101;
        bus.modo     = 1'b0;
        tick();
        check("enb0_no_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        enb          = 1'b1;

        // Backpressure: result held while out_ready=0, new operands refused
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        check("bp_c", 32'(bus.c), 32'h0202);
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_c", 32'(bus.c), 32'h0202);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        enb           = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_enb0_valid", 32'(bus.out_valid), 32'd1);
        enb = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_c", 32'(bus.c), 32'h0202);

        // Reset during SUMA at k=2 aborts the operation
        bus.in_valid = 1'b1;
        bus.modo     = 1'b0;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_c", 32'(bus.c), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("after_rst_ready", 32'(bus.in_ready), 32'd1);
        run_op("fresh", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
